// File: rtl/signed_add_pipe_pkg.sv
// Shared constants and helpers for the chunked signed adder pipeline.
package signed_add_pipe_pkg;

   localparam int OVF_CNT_W = 16;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic logic [63:0] signed_max(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] signed_min(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/signed_add_pipe_stage.sv
// One chunk of the pipelined adder: CW-bit add with carry-in and registered result.
// The final chunk reports signed overflow on its flag output instead of the carry.
module signed_add_pipe_stage
   import signed_add_pipe_pkg::*;
#(
   parameter int CW    = 4,
   parameter bit FINAL = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          in_valid,
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          carry_in,
   output logic          valid,
   output logic [CW-1:0] sum,
   output logic          flag
);

   logic [CW:0] total;
   logic        flag_next;

   assign total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, carry_in};

   if (FINAL) begin : g_ovf
      // carry into the sign bit differs from the carry out exactly on signed overflow
      assign flag_next = total[CW] ^ total[CW-1] ^ a[CW-1] ^ b[CW-1];
   end else begin : g_carry
      assign flag_next = total[CW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         sum   <= '0;
         flag  <= 1'b0;
      end else if (en) begin
         valid <= in_valid;
         if (in_valid) begin
            sum  <= total[CW-1:0];
            flag <= flag_next;
         end
      end
   end

endmodule

// File: rtl/signed_add_pipe.sv
// Pipelined signed adder with overflow detection and per-transaction saturation.
// Optional overflow counter enabled by defining SIGNED_ADD_PIPE_OVF_CNT_EN.
module signed_add_pipe
   import signed_add_pipe_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sat,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
`ifdef SIGNED_ADD_PIPE_OVF_CNT_EN
   ,
   output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

   localparam int               CW      = chunk_width(WIDTH, STAGES);
   localparam logic [WIDTH-1:0] SUM_MAX = WIDTH'(signed_max(WIDTH));
   localparam logic [WIDTH-1:0] SUM_MIN = WIDTH'(signed_min(WIDTH));

   logic             adv;
   logic [WIDTH-1:0] raw_sum;
   logic             final_sat;

   assign adv      = !down_valid || down_ready;
   assign up_ready = adv;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // a_rem/b_rem hold the operand chunks this stage and later stages still need
      localparam int HI = WIDTH - gi * CW;

      logic [HI-1:0]         a_rem;
      logic [HI-1:0]         b_rem;
      logic                  in_valid;
      logic                  in_carry;
      logic                  in_sat;
      logic                  valid;
      logic                  flag;
      logic                  sat_reg;
      logic [CW-1:0]         chunk;
      logic [(gi+1)*CW-1:0]  done;

      if (gi == 0) begin : g_head
         assign a_rem    = a;
         assign b_rem    = b;
         assign in_valid = up_valid;
         assign in_carry = 1'b0;
         assign in_sat   = sat;
         assign done     = chunk;
      end else begin : g_tail
         logic [gi*CW-1:0] lo_reg;

         // operand skew registers move in step with the previous stage's adder
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_rem <= '0;
               b_rem <= '0;
            end else if (adv && g_stage[gi-1].in_valid) begin
               a_rem <= g_stage[gi-1].a_rem[HI+CW-1:CW];
               b_rem <= g_stage[gi-1].b_rem[HI+CW-1:CW];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lo_reg <= '0;
            end else if (adv && in_valid) begin
               lo_reg <= g_stage[gi-1].done;
            end
         end

         assign in_valid = g_stage[gi-1].valid;
         assign in_carry = g_stage[gi-1].flag;
         assign in_sat   = g_stage[gi-1].sat_reg;
         assign done     = {chunk, lo_reg};
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sat_reg <= 1'b0;
         end else if (adv && in_valid) begin
            sat_reg <= in_sat;
         end
      end

      signed_add_pipe_stage #(
         .CW    (CW),
         .FINAL (gi == STAGES - 1)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (adv),
         .in_valid (in_valid),
         .a        (a_rem[CW-1:0]),
         .b        (b_rem[CW-1:0]),
         .carry_in (in_carry),
         .valid    (valid),
         .sum      (chunk),
         .flag     (flag)
      );
   end

   assign raw_sum    = g_stage[STAGES-1].done;
   assign final_sat  = g_stage[STAGES-1].sat_reg;
   assign down_valid = g_stage[STAGES-1].valid;
   assign overflow   = g_stage[STAGES-1].flag;

   // on overflow the wrapped result has the opposite sign of both operands
   always_comb begin
      sum = raw_sum;
      if (final_sat && overflow) begin
         sum = raw_sum[WIDTH-1] ? SUM_MAX : SUM_MIN;
      end
   end

`ifdef SIGNED_ADD_PIPE_OVF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count <= '0;
      end else if (down_valid && down_ready && overflow && (ovf_count != '1)) begin
         ovf_count <= ovf_count + OVF_CNT_W'(1);
      end
   end
`endif

endmodule
